// File: rtl/sd_sector_arbiter.sv
// sd_sector_arbiter
//   Shares one sd_controller between NUM_CLIENTS requesters (0 = track store, 1 = track load,
//   2 = mix load). Grants whole 512-byte sectors round-robin and never splits a sector between
//   clients. A watchdog aborts a transfer when the card stops producing byte strobes.
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   cli_req/we/addr/wdata    per-client request level, direction, sector address, next write byte
//   cli_gnt                  one-hot grant, high from grant until cli_done/cli_err
//   cli_done, cli_err        1-cycle completion / watchdog-abort pulses
//   cli_wstrobe              1-cycle pulse: current write byte consumed
//   rdata, rvalid            read byte and per-client 1-cycle valid pulse
//   sd_*                     sd_controller handshake, address and data
module sd_sector_arbiter #(
  parameter int unsigned NUM_CLIENTS    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CLIENTS-1:0]      cli_req,
  input  logic [NUM_CLIENTS-1:0]      cli_we,
  input  logic [NUM_CLIENTS-1:0][31:0] cli_addr,
  input  logic [NUM_CLIENTS-1:0][7:0] cli_wdata,
  output logic [NUM_CLIENTS-1:0]      cli_gnt,
  output logic [NUM_CLIENTS-1:0]      cli_done,
  output logic [NUM_CLIENTS-1:0]      cli_err,
  output logic [NUM_CLIENTS-1:0]      cli_wstrobe,
  output logic [7:0]                  rdata,
  output logic [NUM_CLIENTS-1:0]      rvalid,
  input  logic                        sd_ready,
  input  logic                        sd_byte_available,
  input  logic                        sd_ready_for_next_byte,
  input  logic [7:0]                  sd_dout,
  output logic                        sd_rd,
  output logic                        sd_wr,
  output logic [31:0]                 sd_addr,
  output logic [7:0]                  sd_din
);

  localparam int unsigned IdxW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StXfer, StFinish} state_e;

  state_e          state_q;
  logic [IdxW-1:0] rr_ptr_q;
  logic [IdxW-1:0] gid_q;
  logic            we_q;
  logic [8:0]      byte_cnt_q;
  logic [31:0]     wd_cnt_q;
  logic            avail_prev_q;
  logic            rfnb_prev_q;

  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  logic [IdxW-1:0] rr_next;
  logic            byte_ev;
  logic            wd_expired;
  int unsigned     cand;

  // Round-robin search: first requester at or after rr_ptr, wrapping cyclically.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= NUM_CLIENTS) cand = cand - NUM_CLIENTS;
      if (!pick_valid && cli_req[IdxW'(cand)]) begin
        pick_valid = 1'b1;
        pick_idx   = IdxW'(cand);
      end
    end
  end

  always_comb begin
    rr_next    = (gid_q == IdxW'(NUM_CLIENTS - 1)) ? '0 : gid_q + 1'b1;
    // Only the strobe matching the current direction counts as a byte event.
    byte_ev    = we_q ? (sd_ready_for_next_byte & ~rfnb_prev_q)
                      : (sd_byte_available & ~avail_prev_q);
    wd_expired = (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1));
  end

  // Write data comes straight from the granted client's FIFO head.
  assign sd_din = cli_wdata[gid_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      gid_q        <= '0;
      we_q         <= 1'b0;
      byte_cnt_q   <= '0;
      wd_cnt_q     <= '0;
      avail_prev_q <= 1'b0;
      rfnb_prev_q  <= 1'b0;
      cli_gnt      <= '0;
      cli_done     <= '0;
      cli_err      <= '0;
      cli_wstrobe  <= '0;
      rvalid       <= '0;
      rdata        <= '0;
      sd_rd        <= 1'b0;
      sd_wr        <= 1'b0;
      sd_addr      <= '0;
    end else begin
      avail_prev_q <= sd_byte_available;
      rfnb_prev_q  <= sd_ready_for_next_byte;
      cli_done     <= '0;
      cli_err      <= '0;
      cli_wstrobe  <= '0;
      rvalid       <= '0;

      unique case (state_q)
        StIdle: begin
          if (pick_valid && sd_ready) begin
            gid_q             <= pick_idx;
            we_q              <= cli_we[pick_idx];
            sd_addr           <= {cli_addr[pick_idx][31:9], 9'b0};
            cli_gnt           <= '0;
            cli_gnt[pick_idx] <= 1'b1;
            sd_rd             <= ~cli_we[pick_idx];
            sd_wr             <= cli_we[pick_idx];
            wd_cnt_q          <= '0;
            state_q           <= StIssue;
          end
        end

        StIssue: begin
          if (wd_expired) begin
            sd_rd          <= 1'b0;
            sd_wr          <= 1'b0;
            cli_err[gid_q] <= 1'b1;
            cli_gnt        <= '0;
            rr_ptr_q       <= rr_next;
            byte_cnt_q     <= '0;
            state_q        <= StIdle;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
            if (!sd_ready) state_q <= StXfer;
          end
        end

        StXfer: begin
          if (byte_ev) begin
            wd_cnt_q   <= '0;
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (we_q) begin
              cli_wstrobe[gid_q] <= 1'b1;
            end else begin
              rdata         <= sd_dout;
              rvalid[gid_q] <= 1'b1;
            end
            if (byte_cnt_q == 9'd511) begin
              sd_rd   <= 1'b0;
              sd_wr   <= 1'b0;
              state_q <= StFinish;
            end
          end else if (wd_expired) begin
            sd_rd          <= 1'b0;
            sd_wr          <= 1'b0;
            cli_err[gid_q] <= 1'b1;
            cli_gnt        <= '0;
            rr_ptr_q       <= rr_next;
            byte_cnt_q     <= '0;
            state_q        <= StIdle;
          end else begin
            wd_cnt_q <= wd_cnt_q + 1'b1;
          end
        end

        StFinish: begin
          cli_done[gid_q] <= 1'b1;
          cli_gnt         <= '0;
          rr_ptr_q        <= rr_next;
          byte_cnt_q      <= '0;
          state_q         <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
